camera_pixel_assembler: RTL and testbench

Consumes the parallel DVP pixel bus of the image sensor once the sensor's register initialisation over SCCB has completed, and turns byte pairs into 16-bit RGB565 pixels in the system clock domain. Oversamples the camera's PCLK/HSYNC/VSYNC/DATA with the system clock and emits one valid-qualified pixel per two bytes. Also emits horizontal/vertical coordinates and a frame-start pulse for the downstream frame buffer writer.

---
 rtl/camera_pixel_assembler.sv | 206 ++++++++++++++++++++
 tb/tb_camera_pixel_assembler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_assembler.sv
// camera_pixel_assembler
//
// Turns the parallel DVP byte stream of an image sensor into 16-bit RGB565
// pixels in the system clock domain. The camera pins are oversampled by
// clk_in. Every PCLK rising edge seen on the synchronized copy is an "edge
// cycle", and the framing state machine advances only on edge cycles.
// Coordinates and a frame-start strobe go to the frame buffer writer.
//
// Ports
//   clk_in            system clock
//   rst_in            asynchronous, active-high reset
//   camera_pclk_in    raw camera pixel clock (sampled as data)
//   camera_hs_in      raw HREF, high while line bytes are present
//   camera_vs_in      raw VSYNC, high during vertical blanking
//   camera_data_in    raw camera byte
//   pixel_valid_out   one-cycle strobe, pixel fields valid
//   pixel_data_out    {first byte, second byte}, holds between strobes
//   pixel_hcount_out  column of the pixel, holds between strobes
//   pixel_vcount_out  row of the pixel, holds between strobes
//   frame_start_out   one-cycle strobe at the VSYNC falling edge
//   line_error_out    one-cycle strobe when a line ends on an odd byte
//
// Handshake: pixel_valid_out is a pure strobe. There is no ready and no
// backpressure, so the consumer must take the fields in the strobe cycle.
module camera_pixel_assembler #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        camera_pclk_in,
    input  logic                        camera_hs_in,
    input  logic                        camera_vs_in,
    input  logic [7:0]                  camera_data_in,
    output logic                        pixel_valid_out,
    output logic [15:0]                 pixel_data_out,
    output logic [$clog2(H_ACTIVE)-1:0] pixel_hcount_out,
    output logic [$clog2(V_ACTIVE)-1:0] pixel_vcount_out,
    output logic                        frame_start_out,
    output logic                        line_error_out
);

    localparam int HOW = $clog2(H_ACTIVE);
    localparam int VOW = $clog2(V_ACTIVE);
    // One extra bit so the counters can rest at the saturation value.
    localparam int HCW = HOW + 1;
    localparam int VCW = VOW + 1;
    localparam logic [HCW-1:0] H_LIMIT = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0] V_LIMIT = VCW'(V_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BLANK      = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    // All camera inputs share one identical two-flop chain, so they stay
    // mutually aligned. The third PCLK flop provides the rising-edge detect.
    logic       pclk_s1, pclk_s2, pclk_d;
    logic       hs_s1, hs_s2;
    logic       vs_s1, vs_s2;
    logic [7:0] data_s1, data_s2;
    logic       pclk_rise;

    state_t           state, state_n;
    logic [HCW-1:0]   hcount, hcount_n;
    logic [VCW-1:0]   vcount, vcount_n;
    logic             phase, phase_n;
    logic [7:0]       hi_byte, hi_byte_n;
    logic             hs_prev, hs_prev_n;

    logic             valid_n, frame_start_n, line_error_n;
    logic [15:0]      data_n;
    logic [HOW-1:0]   hout_n;
    logic [VOW-1:0]   vout_n;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pclk_s1 <= 1'b0;
            pclk_s2 <= 1'b0;
            pclk_d  <= 1'b0;
            hs_s1   <= 1'b0;
            hs_s2   <= 1'b0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            data_s1 <= 8'd0;
            data_s2 <= 8'd0;
        end else begin
            pclk_s1 <= camera_pclk_in;
            pclk_s2 <= pclk_s1;
            pclk_d  <= pclk_s2;
            hs_s1   <= camera_hs_in;
            hs_s2   <= hs_s1;
            vs_s1   <= camera_vs_in;
            vs_s2   <= vs_s1;
            data_s1 <= camera_data_in;
            data_s2 <= data_s1;
        end
    end

    assign pclk_rise = pclk_s2 & ~pclk_d;

    always_comb begin
        state_n       = state;
        hcount_n      = hcount;
        vcount_n      = vcount;
        phase_n       = phase;
        hi_byte_n     = hi_byte;
        hs_prev_n     = hs_prev;
        valid_n       = 1'b0;
        frame_start_n = 1'b0;
        line_error_n  = 1'b0;
        data_n        = pixel_data_out;
        hout_n        = pixel_hcount_out;
        vout_n        = pixel_vcount_out;

        if (pclk_rise) begin
            case (state)
                WAIT_FRAME: begin
                    // Only a full VSYNC blanking period can start a frame,
                    // so a partial frame after reset is never emitted.
                    hs_prev_n = 1'b0;
                    if (vs_s2) begin
                        state_n = BLANK;
                    end
                end
                BLANK: begin
                    hcount_n  = '0;
                    vcount_n  = '0;
                    phase_n   = 1'b0;
                    hs_prev_n = 1'b0;
                    if (!vs_s2) begin
                        state_n       = ACTIVE;
                        frame_start_n = 1'b1;
                    end
                end
                ACTIVE: begin
                    hs_prev_n = hs_s2;
                    if (vs_s2) begin
                        // VSYNC wins over a simultaneous HREF fall: a frame
                        // cut mid-line is not reported as a line error.
                        state_n = BLANK;
                    end else if (hs_s2) begin
                        if (!phase) begin
                            hi_byte_n = data_s2;
                            phase_n   = 1'b1;
                        end else begin
                            if ((hcount < H_LIMIT) && (vcount < V_LIMIT)) begin
                                valid_n = 1'b1;
                                data_n  = {hi_byte, data_s2};
                                hout_n  = hcount[HOW-1:0];
                                vout_n  = vcount[VOW-1:0];
                            end
                            if (hcount != H_LIMIT) begin
                                hcount_n = hcount + HCW'(1);
                            end
                            phase_n = 1'b0;
                        end
                    end else if (hs_prev) begin
                        // HREF falling edge closes the line.
                        line_error_n = phase;
                        if (vcount != V_LIMIT) begin
                            vcount_n = vcount + VCW'(1);
                        end
                        hcount_n = '0;
                        phase_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = WAIT_FRAME;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= WAIT_FRAME;
            hcount           <= '0;
            vcount           <= '0;
            phase            <= 1'b0;
            hi_byte          <= 8'd0;
            hs_prev          <= 1'b0;
            pixel_valid_out  <= 1'b0;
            pixel_data_out   <= 16'd0;
            pixel_hcount_out <= '0;
            pixel_vcount_out <= '0;
            frame_start_out  <= 1'b0;
            line_error_out   <= 1'b0;
        end else begin
            state            <= state_n;
            hcount           <= hcount_n;
            vcount           <= vcount_n;
            phase            <= phase_n;
            hi_byte          <= hi_byte_n;
            hs_prev          <= hs_prev_n;
            pixel_valid_out  <= valid_n;
            pixel_data_out   <= data_n;
            pixel_hcount_out <= hout_n;
            pixel_vcount_out <= vout_n;
            frame_start_out  <= frame_start_n;
            line_error_out   <= line_error_n;
        end
    end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Testbench for camera_pixel_assembler with a small active window (4 x 2).
// Frames are built as lists of lines of bytes. The expected strobes follow
// from the framing rules: one frame start per frame, pixel k of line l only
// when k < H and l < V, and a line error for an odd line that ends with HREF.
// A monitor pops one expected event per observed strobe.
module tb_camera_pixel_assembler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HB = $clog2(H);
  localparam int VB = $clog2(V);
  localparam int EW = 2 + 16 + HB + VB;

  localparam logic [1:0] EV_PIX = 2'd0;
  localparam logic [1:0] EV_FS  = 2'd1;
  localparam logic [1:0] EV_LE  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pclk = 1'b0;
  logic hs = 1'b0;
  logic vs = 1'b0;
  logic [7:0] data = 8'd0;

  logic          pixel_valid;
  logic [15:0]   pixel_data;
  logic [HB-1:0] pixel_hcount;
  logic [VB-1:0] pixel_vcount;
  logic          frame_start;
  logic          line_error;

  always #5 clk = ~clk;

  camera_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .camera_pclk_in   (pclk),
    .camera_hs_in     (hs),
    .camera_vs_in     (vs),
    .camera_data_in   (data),
    .pixel_valid_out  (pixel_valid),
    .pixel_data_out   (pixel_data),
    .pixel_hcount_out (pixel_hcount),
    .pixel_vcount_out (pixel_vcount),
    .frame_start_out  (frame_start),
    .line_error_out   (line_error)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    line_q[$];
  int total = 0;
  int bad = 0;
  int ev_seen = 0;
  int px_seen = 0;
  logic [15:0] last_px = 16'd0;
  int lo_cyc = 2;
  int hi_cyc = 2;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_ev(logic [1:0] k, logic [15:0] d, int h, int v);
    exp_q.push_back({k, d, HB'(h), VB'(v)});
  endfunction

  // Reference: pixels of line l from its byte list.
  function automatic void expect_line(int l);
    for (int k = 0; k < line_q.size() / 2; k++) begin
      if (k < H && l < V) begin
        push_ev(EV_PIX, {line_q[2*k], line_q[2*k+1]}, k, l);
        last_px = {line_q[2*k], line_q[2*k+1]};
      end
    end
  endfunction

  // Monitor: samples on the falling clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      logic [1:0] k_act;
      logic [EW-1:0] e;
      n = int'(pixel_valid) + int'(frame_start) + int'(line_error);
      if (n > 1) begin
        check("strobe_overlap", 32'(n), 32'd1);
      end else if (n == 1) begin
        ev_seen++;
        if (pixel_valid) px_seen++;
        k_act = pixel_valid ? EV_PIX : (frame_start ? EV_FS : EV_LE);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_kind", 32'(k_act), 32'hFF);
        end else begin
          e = exp_q.pop_front();
          check("ev_kind", 32'(k_act), 32'(e[EW-1 -: 2]));
          if (k_act == EV_PIX && e[EW-1 -: 2] == EV_PIX) begin
            check("pix_data", 32'(pixel_data), 32'(e[HB+VB +: 16]));
            check("pix_hcount", 32'(pixel_hcount), 32'(e[VB +: HB]));
            check("pix_vcount", 32'(pixel_vcount), 32'(e[VB-1:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Camera changes HREF/VSYNC/DATA at the PCLK falling edge.
  task automatic cam_edge(input logic h, input logic v, input logic [7:0] d);
    @(negedge clk);
    pclk = 1'b0; hs = h; vs = v; data = d;
    repeat (lo_cyc - 1) @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    repeat (hi_cyc - 1) @(negedge clk);
  endtask

  task automatic blank(input int n);
    repeat (n) cam_edge(1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic gap(input int n);
    repeat (n) cam_edge(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_bytes();
    foreach (line_q[i]) cam_edge(1'b1, 1'b0, line_q[i]);
  endtask

  // Line l from line_q; a truncated line is cut by VSYNC instead of HREF.
  task automatic run_line(input int l, input bit trunc);
    expect_line(l);
    if (!trunc && line_q.size() % 2 == 1) push_ev(EV_LE, 16'd0, 0, 0);
    send_bytes();
    if (!trunc) gap($urandom_range(1, 3));
  endtask

  task automatic start_frame();
    blank(2);
    push_ev(EV_FS, 16'd0, 0, 0);
    gap($urandom_range(1, 2));
  endtask

  task automatic fill_line(input int nb, input logic [7:0] base, input bit rnd);
    line_q.delete();
    for (int i = 0; i < nb; i++) line_q.push_back(rnd ? 8'($urandom) : base + 8'(i));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ev0, px0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          32'({pixel_valid, pixel_data, pixel_hcount, pixel_vcount, frame_start, line_error}), 32'd0);

    // Bytes before any VSYNC high must be ignored.
    ev0 = ev_seen;
    fill_line(6, 8'h40, 1'b0);
    send_bytes();
    gap(2);
    send_bytes();
    gap(2);
    repeat (8) @(negedge clk);
    check("pre_vs_strobes", 32'(ev_seen - ev0), 32'd0);

    // Basic frame: 2 lines x 4 bytes.
    start_frame();
    line_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_line(0, 1'b0);
    run_line(1, 1'b0);
    blank(2);
    drain();

    // Odd line followed by an even line.
    start_frame();
    fill_line(5, 8'hA1, 1'b0);
    run_line(0, 1'b0);
    fill_line(4, 8'hB1, 1'b0);
    run_line(1, 1'b0);
    blank(2);
    drain();

    // Window clipping: 3 lines x 12 bytes -> 8 pixels.
    px0 = px_seen;
    start_frame();
    for (int l = 0; l < 3; l++) begin
      fill_line(12, 8'(16 * l), 1'b0);
      run_line(l, 1'b0);
    end
    blank(2);
    drain();
    check("clip_pixel_count", 32'(px_seen - px0), 32'd8);

    // Reset mid-pixel.
    start_frame();
    line_q = '{8'hC1, 8'hC2};
    expect_line(0);
    send_bytes();
    cam_edge(1'b1, 1'b0, 8'hC3);
    drain();
    check("pre_reset_data", 32'(pixel_data), 32'h0000C1C2);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             32'({pixel_valid, pixel_data, pixel_hcount, pixel_vcount, frame_start, line_error}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev0 = ev_seen;
    cam_edge(1'b1, 1'b0, 8'hC4);
    cam_edge(1'b1, 1'b0, 8'hC5);
    cam_edge(1'b1, 1'b0, 8'hC6);
    gap(2);
    repeat (8) @(negedge clk);
    check("post_reset_silence", 32'(ev_seen - ev0), 32'd0);
    start_frame();
    fill_line(4, 8'hD1, 1'b0);
    run_line(0, 1'b0);
    blank(2);
    drain();

    // Random frames with PCLK at clk/3.
    lo_cyc = 1;
    hi_cyc = 2;
    for (int f = 0; f < 4; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      start_frame();
      for (int l = 0; l < nl; l++) begin
        fill_line($urandom_range(1, 12), 8'd0, 1'b1);
        run_line(l, (l == nl - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end
    blank(2);
    drain();
    check("data_hold", 32'(pixel_data), 32'(last_px));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
